// File: rtl/mem_addr_prefetch_unit.sv
// Prefetch FIFO of allocated 2 KB buffer addresses for the RX writer, plus the
// arbiter that shares the allocator's single free port between TX frees and flush returns.
module mem_addr_prefetch_unit #(
    parameter int AXI_ADDR_WIDTH    = 32,
    parameter int PACKET_SIZE_WIDTH = 11,
    parameter int PREFETCH_DEPTH    = 4,
    parameter int FILL_WIDTH        = $clog2(PREFETCH_DEPTH + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [AXI_ADDR_WIDTH-1:0]    alloc_addr_i,
    input  logic                         alloc_addr_valid_i,
    output logic                         alloc_addr_ack_o,
    output logic [PACKET_SIZE_WIDTH-1:0] alloc_packet_length_o,
    output logic [AXI_ADDR_WIDTH-1:0]    addr_o,
    output logic                         addr_valid_o,
    input  logic                         addr_ready_i,
    input  logic                         flush_i,
    output logic                         flush_busy_o,
    input  logic [AXI_ADDR_WIDTH-1:0]    tx_free_addr_i,
    input  logic                         tx_free_i,
    output logic                         tx_free_ack_o,
    output logic [AXI_ADDR_WIDTH-1:0]    free_mem_addr_o,
    output logic                         free_mem_o,
    input  logic                         free_mem_ack_i,
    output logic [FILL_WIDTH-1:0]        fill_level_o
);

    localparam int PTR_W = $clog2(PREFETCH_DEPTH);
    localparam logic [FILL_WIDTH-1:0] DEPTH_FILL = FILL_WIDTH'(PREFETCH_DEPTH);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_TX,
        ARB_FL
    } arb_e;

    state_e state_q;
    arb_e   arb_q;

    logic [AXI_ADDR_WIDTH-1:0] mem_q [PREFETCH_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [FILL_WIDTH-1:0]     fill_q, fill_d;

    logic [AXI_ADDR_WIDTH-1:0] head;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;

    assign head       = mem_q[rd_ptr_q];
    assign fifo_empty = (fill_q == '0);

    assign alloc_addr_ack_o      = alloc_addr_valid_i && (fill_q < DEPTH_FILL) && (state_q == ST_RUN);
    assign alloc_packet_length_o = '1;
    assign push                  = alloc_addr_ack_o;

    assign addr_valid_o = !fifo_empty && (state_q == ST_RUN);
    assign addr_o       = fifo_empty ? '0 : head;
    assign fill_level_o = fill_q;
    assign flush_busy_o = (state_q == ST_FLUSH);

    // RX pops only in RUN and flush pops only in FL (which implies FLUSH), so they never coincide.
    assign pop = (addr_valid_o && addr_ready_i) || ((arb_q == ARB_FL) && free_mem_ack_i);

    assign free_mem_o    = (arb_q != ARB_IDLE);
    assign tx_free_ack_o = (arb_q == ARB_TX) && free_mem_ack_i;

    always_comb begin
        free_mem_addr_o = '0;
        case (arb_q)
            ARB_TX:  free_mem_addr_o = tx_free_addr_i;
            ARB_FL:  free_mem_addr_o = head;
            default: free_mem_addr_o = '0;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            fill_d = fill_q + FILL_WIDTH'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - FILL_WIDTH'(1);
        end
    end

    // Storage is not reset: entries are only visible through fill_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= alloc_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            arb_q    <= ARB_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;

            case (state_q)
                ST_RUN:   if (flush_i) state_q <= ST_FLUSH;
                ST_FLUSH: if (fifo_empty && (arb_q != ARB_FL)) state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase

            // A grant is held until the allocator acks, so the free address never changes mid-request.
            case (arb_q)
                ARB_IDLE: begin
                    if (tx_free_i) begin
                        arb_q <= ARB_TX;
                    end else if ((state_q == ST_FLUSH) && !fifo_empty) begin
                        arb_q <= ARB_FL;
                    end
                end
                ARB_TX, ARB_FL: if (free_mem_ack_i) arb_q <= ARB_IDLE;
                default: arb_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_addr_prefetch_unit.sv
// Directed and random stimulus for mem_addr_prefetch_unit, checked every cycle
// against a queue-based reference model of the prefetch FIFO, flush mode and free grant.
module tb_mem_addr_prefetch_unit;

    localparam int AW    = 32;
    localparam int PW    = 11;
    localparam int DEPTH = 4;
    localparam int FW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] alloc_addr_i;
    logic          alloc_addr_valid_i;
    logic          alloc_addr_ack_o;
    logic [PW-1:0] alloc_packet_length_o;
    logic [AW-1:0] addr_o;
    logic          addr_valid_o;
    logic          addr_ready_i;
    logic          flush_i;
    logic          flush_busy_o;
    logic [AW-1:0] tx_free_addr_i;
    logic          tx_free_i;
    logic          tx_free_ack_o;
    logic [AW-1:0] free_mem_addr_o;
    logic          free_mem_o;
    logic          free_mem_ack_i;
    logic [FW-1:0] fill_level_o;

    always #5 clk_i = ~clk_i;

    mem_addr_prefetch_unit #(
        .AXI_ADDR_WIDTH(AW), .PACKET_SIZE_WIDTH(PW), .PREFETCH_DEPTH(DEPTH), .FILL_WIDTH(FW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alloc_addr_i(alloc_addr_i), .alloc_addr_valid_i(alloc_addr_valid_i),
        .alloc_addr_ack_o(alloc_addr_ack_o), .alloc_packet_length_o(alloc_packet_length_o),
        .addr_o(addr_o), .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
        .flush_i(flush_i), .flush_busy_o(flush_busy_o),
        .tx_free_addr_i(tx_free_addr_i), .tx_free_i(tx_free_i), .tx_free_ack_o(tx_free_ack_o),
        .free_mem_addr_o(free_mem_addr_o), .free_mem_o(free_mem_o),
        .free_mem_ack_i(free_mem_ack_i), .fill_level_o(fill_level_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the prefetched addresses in order, whether a flush is draining, and who holds the free port.
    logic [AW-1:0] m_q[$];
    bit            m_flush;
    int            m_grant;          // 0 none, 1 TX, 2 flush return
    bit            en_chk;

    bit            last_ack;
    bit            last_tx_ack;
    int            n_acks;
    int            n_tx_acks;
    logic [AW-1:0] frees[$];
    logic [AW-1:0] emitted[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model for the current inputs, clock, then advance the model.
    task automatic cycle();
        int            sz;
        bit            e_ack, e_av, e_tx_ack, e_pop, f;
        int            g;
        logic [AW-1:0] e_head, e_faddr;
        #1;
        sz       = m_q.size();
        e_head   = (sz != 0) ? m_q[0] : '0;
        e_ack    = alloc_addr_valid_i && (sz < DEPTH) && !m_flush;
        e_av     = (sz != 0) && !m_flush;
        e_tx_ack = (m_grant == 1) && free_mem_ack_i;
        e_faddr  = (m_grant == 1) ? tx_free_addr_i : (m_grant == 2) ? e_head : '0;
        if (en_chk) begin
            chk("alloc_ack", alloc_addr_ack_o, e_ack);
            chk("addr_valid", addr_valid_o, e_av);
            chk("addr", addr_o, e_head);
            chk("fill", fill_level_o, sz);
            chk("flush_busy", flush_busy_o, m_flush);
            chk("free_mem", free_mem_o, m_grant != 0);
            chk("free_addr", free_mem_addr_o, e_faddr);
            chk("tx_ack", tx_free_ack_o, e_tx_ack);
            if (e_ack) chk("pkt_len", alloc_packet_length_o, 2047);
        end
        last_ack    = e_ack;
        last_tx_ack = e_tx_ack;
        if (alloc_addr_ack_o) n_acks++;
        if (tx_free_ack_o) n_tx_acks++;
        if (addr_valid_o && addr_ready_i) emitted.push_back(addr_o);
        if ((m_grant != 0) && free_mem_ack_i) frees.push_back(free_mem_addr_o);
        e_pop = (e_av && addr_ready_i) || ((m_grant == 2) && free_mem_ack_i);
        @(posedge clk_i);
        if (rst_i) begin
            m_q.delete();
            m_flush = 1'b0;
            m_grant = 0;
        end else begin
            f = m_flush;
            g = m_grant;
            if (!f) m_flush = flush_i;
            else if ((sz == 0) && (g != 2)) m_flush = 1'b0;
            if (g == 0) m_grant = tx_free_i ? 1 : (f && (sz != 0)) ? 2 : 0;
            else if (free_mem_ack_i) m_grant = 0;
            if (e_pop) void'(m_q.pop_front());
            if (e_ack) m_q.push_back(alloc_addr_i);
        end
        #1;
    endtask

    task automatic push_addr(input logic [AW-1:0] a);
        alloc_addr_valid_i = 1'b1;
        alloc_addr_i       = a;
        cycle();
        alloc_addr_valid_i = 1'b0;
    endtask

    // Serve the free port with a fixed ack delay until flush and any TX request are finished.
    task automatic run_flush(input int dly, input int budget);
        int waited = 0;
        int g0;
        for (int n = 0; n < budget; n++) begin
            free_mem_ack_i = (m_grant != 0) && (waited >= dly);
            g0 = m_grant;
            cycle();
            if (free_mem_ack_i) waited = 0;
            else if (g0 != 0) waited++;
            free_mem_ack_i = 1'b0;
            if (last_tx_ack) tx_free_i = 1'b0;
            if (!m_flush && (m_grant == 0) && !tx_free_i) break;
        end
        chk("flush_done_busy", flush_busy_o, 0);
        chk("flush_done_free", free_mem_o, 0);
    endtask

    initial begin
        logic [AW-1:0] offers[5];
        logic [AW-1:0] a;
        int            idx;

        rst_i = 1'b1; alloc_addr_i = '0; alloc_addr_valid_i = 1'b0; addr_ready_i = 1'b0;
        flush_i = 1'b0; tx_free_addr_i = '0; tx_free_i = 1'b0; free_mem_ack_i = 1'b0;
        en_chk = 1'b0; m_flush = 1'b0; m_grant = 0; n_acks = 0; n_tx_acks = 0;
        cycle();
        en_chk = 1'b1;
        cycle();
        rst_i = 1'b0;
        chk("rst_fill", fill_level_o, 0);
        chk("rst_busy", flush_busy_o, 0);

        // Offer five addresses back-to-back; only four fit.
        offers = '{32'h0000_0800, 32'h0000_1000, 32'h0000_1800, 32'h0000_2000, 32'h0000_2800};
        idx = 0;
        alloc_addr_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alloc_addr_i = offers[idx];
            cycle();
            if (last_ack) idx++;
        end
        chk("tp1_fill", fill_level_o, 4);
        chk("tp1_acks", n_acks, 4);
        chk("tp1_fifth_ack", alloc_addr_ack_o, 0);

        // Drain two while the fifth address is still offered.
        addr_ready_i = 1'b1;
        repeat (2) begin
            cycle();
            if (last_ack) alloc_addr_valid_i = 1'b0;
        end
        addr_ready_i = 1'b0;
        alloc_addr_valid_i = 1'b0;
        chk("tp2_first", emitted[0], 32'h0000_0800);
        chk("tp2_second", emitted[1], 32'h0000_1000);
        chk("tp2_fill", fill_level_o, 3);
        chk("tp2_acks", n_acks, 5);

        // Flush three entries with a two-cycle allocator ack; an offer stays pending throughout.
        frees.delete();
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        alloc_addr_valid_i = 1'b1;
        alloc_addr_i = 32'h0000_5000;
        run_flush(2, 60);
        alloc_addr_valid_i = 1'b0;
        chk("tp3_nfree", frees.size(), 3);
        chk("tp3_free0", frees[0], 32'h0000_1800);
        chk("tp3_free1", frees[1], 32'h0000_2000);
        chk("tp3_free2", frees[2], 32'h0000_2800);
        chk("tp3_acks", n_acks, 5);
        chk("tp3_fill", fill_level_o, 0);

        // TX request during flush while the arbiter is idle wins first.
        push_addr(32'h0000_3000);
        push_addr(32'h0000_3800);
        frees.delete();
        n_tx_acks = 0;
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        tx_free_i = 1'b1;
        tx_free_addr_i = 32'h0001_0000;
        run_flush(2, 60);
        chk("tp4_nfree", frees.size(), 3);
        chk("tp4_free0", frees[0], 32'h0001_0000);
        chk("tp4_free1", frees[1], 32'h0000_3000);
        chk("tp4_free2", frees[2], 32'h0000_3800);
        chk("tp4_txacks", n_tx_acks, 1);

        // TX grant held with a slow ack while a flush is requested behind it.
        push_addr(32'h0000_4000);
        push_addr(32'h0000_4800);
        frees.delete();
        tx_free_i = 1'b1;
        tx_free_addr_i = 32'h0001_0000;
        cycle();
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        repeat (4) begin
            cycle();
            chk("tp5_hold_addr", free_mem_addr_o, 32'h0001_0000);
            chk("tp5_no_fl_pop", fill_level_o, 2);
        end
        run_flush(0, 60);
        chk("tp5_nfree", frees.size(), 3);
        chk("tp5_free0", frees[0], 32'h0001_0000);
        chk("tp5_free1", frees[1], 32'h0000_4000);
        chk("tp5_free2", frees[2], 32'h0000_4800);

        // Empty flush lasts one cycle.
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        chk("tp6_busy", flush_busy_o, 1);
        cycle();
        chk("tp6_run", flush_busy_o, 0);

        // Reset in the middle of a flush with two entries.
        push_addr(32'h0000_6000);
        push_addr(32'h0000_6800);
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        chk("tp6_rst_fill", fill_level_o, 0);
        chk("tp6_rst_valid", addr_valid_o, 0);
        chk("tp6_rst_addr", addr_o, 0);
        chk("tp6_rst_busy", flush_busy_o, 0);
        chk("tp6_rst_free", free_mem_o, 0);
        chk("tp6_rst_faddr", free_mem_addr_o, 0);
        chk("tp6_rst_txack", tx_free_ack_o, 0);

        // Random traffic respecting the hold-until-ack protocols.
        for (int i = 0; i < 1500; i++) begin
            if (!alloc_addr_valid_i || last_ack) begin
                a = $urandom;
                a[10:0] = '0;
                alloc_addr_i = a;
                alloc_addr_valid_i = ($urandom_range(2) != 0);
            end
            if (tx_free_i && last_tx_ack) tx_free_i = 1'b0;
            else if (!tx_free_i && ($urandom_range(9) == 0)) begin
                tx_free_i = 1'b1;
                tx_free_addr_i = $urandom;
            end
            addr_ready_i   = $urandom_range(1) != 0;
            flush_i        = $urandom_range(19) == 0;
            free_mem_ack_i = $urandom_range(2) == 0;
            rst_i          = $urandom_range(299) == 0;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_addr_prefetch_unit.md
Name: mem_addr_prefetch_unit

Overview:
- Sits between mem_alloc_unit and the RX packet writer.
- Accepts allocated 2 KB buffer addresses from the allocator's valid/ack port into a small FIFO, so the writer gets an address with zero search latency.
- Owns the allocator's single free port: arbitrates TX-side free requests against flush-return of unused prefetched addresses.

Parameters:
- AXI_ADDR_WIDTH, 32, width of buffer addresses.
- PACKET_SIZE_WIDTH, 11, width of packet length field on the allocator port.
- PREFETCH_DEPTH, 4, number of prefetched addresses held; must be a power of two, at least 2.
- FILL_WIDTH, $clog2(PREFETCH_DEPTH+1), width of the fill-level output.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- alloc_addr_i  in  AXI_ADDR_WIDTH  address offered by allocator.
- alloc_addr_valid_i  in  1  allocator offer valid.
- alloc_addr_ack_o  out  1  accept of offered address.
- alloc_packet_length_o  out  PACKET_SIZE_WIDTH  length reported with ack.
- addr_o  in/out: out  AXI_ADDR_WIDTH  FIFO head address to RX writer.
- addr_valid_o  out  1  head valid.
- addr_ready_i  in  1  RX writer takes head.
- flush_i  in  1  single-cycle request to return all prefetched addresses.
- flush_busy_o  out  1  high while flush in progress.
- tx_free_addr_i  in  AXI_ADDR_WIDTH  address TX side wants freed.
- tx_free_i  in  1  TX free request; held until tx_free_ack_o.
- tx_free_ack_o  out  1  TX free completed.
- free_mem_addr_o  out  AXI_ADDR_WIDTH  to allocator free port.
- free_mem_o  out  1  free request to allocator; held until ack.
- free_mem_ack_i  in  1  allocator free completed.
- fill_level_o  out  FILL_WIDTH  entries in FIFO.

Behaviour:
- Reset: FIFO empty, fill_level_o=0, main state RUN, arbiter IDLE; all valid/ack/request outputs 0, flush_busy_o=0. Reset mid-flush discards FIFO contents; the allocator shares rst_i, so nothing leaks.
- alloc_addr_ack_o is combinational: alloc_addr_valid_i && fill<PREFETCH_DEPTH && state==RUN.
- Push on alloc_addr_valid_i && alloc_addr_ack_o; one push at most per cycle.
- alloc_packet_length_o is constant all-ones (2047): full block reserved.
- addr_o is the FIFO head. addr_valid_o = fill!=0 && state==RUN.
- Pop on addr_valid_o && addr_ready_i. Push and pop in the same cycle leave fill unchanged.
- FIFO pointers wrap modulo PREFETCH_DEPTH. Never overflows; pop on empty is impossible because valid gates it.
- Main FSM:
  - RUN: flush_i -> FLUSH, flush_busy_o=1 from the next cycle.
  - FLUSH: no acks to allocator, addr_valid_o=0. Go to RUN when fill==0 and arbiter not in FL. flush_i in FLUSH is ignored. flush_i with an empty FIFO takes one FLUSH cycle, then RUN.
- Free arbiter, registered grant:
  - IDLE: tx_free_i -> TX (TX has priority); else FLUSH && fill!=0 -> FL. free_mem_o=0.
  - TX: free_mem_o=1, free_mem_addr_o=tx_free_addr_i, tx_free_ack_o=free_mem_ack_i. On ack -> IDLE.
  - FL: free_mem_o=1, free_mem_addr_o=FIFO head. On ack, pop the head -> IDLE.
  - Grant never switches before ack; the address stays stable for the whole request.
  - Minimum gap between successive frees is one IDLE cycle.
- A free_mem_ack_i that arrives in IDLE is ignored.

Test Plan:
- After reset, the allocator offers 0x0000_0800, 0x0000_1000, 0x0000_1800, 0x0000_2000, 0x0000_2800 back-to-back with addr_ready_i=0. Required: first four acked, fill=4, fifth not acked, alloc_packet_length_o=2047 on each ack.
- Fill=4, then addr_ready_i=1 for 2 cycles while the allocator offers 0x0000_2800. Required: 0x0800 then 0x1000 emitted in order, 0x2800 pushed, fill ends at 3.
- Fill=3, flush_i pulse, allocator free ack after 2 cycles each. Required: free_mem_addr_o sequence 0x1800, 0x2000, 0x2800; addr_valid_o=0 and no alloc acks throughout; flush_busy_o drops after fill=0; RUN resumes.
- During flush, tx_free_i with 0x0001_0000 raised while arbiter IDLE. Required: TX granted first, tx_free_ack_o pulses once, then flush entries resume.
- TX request granted, free_mem_ack_i delayed 5 cycles while FIFO has entries and flush_i is pulsed. Required: free_mem_addr_o stays 0x0001_0000 until ack, no FL grant before ack.
- flush_i asserted with FIFO empty, and rst_i asserted mid-flush with fill=2. Required: the empty flush returns to RUN after 1 cycle; the reset gives fill=0, all outputs 0 the next cycle.
